// File: rtl/cp0_pkg.sv
// Shared CP0 constants and helpers for the interrupt-pending path.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;

    localparam int IP_TIMER  = 7;
    localparam int IP_EXT_LO = 2;
    localparam int IP_SW_LO  = 0;

    localparam logic [4:0] EXC_INT = 5'd0;

    // Bit layout matches Cause IP[15:8]: timer on top, software bits at the bottom.
    function automatic logic [7:0] pack_interrupts(
        input logic       timer,
        input logic [4:0] ext,
        input logic [1:0] sw
    );
        logic [7:0] ip;
        ip                     = 8'h00;
        ip[IP_TIMER]           = timer;
        ip[IP_EXT_LO +: 5]     = ext;
        ip[IP_SW_LO +: 2]      = sw;
        return ip;
    endfunction

    function automatic logic irq_wanted(
        input logic       ie,
        input logic       exl,
        input logic [7:0] ip,
        input logic [7:0] im
    );
        return ie & ~exl & (|(ip & im));
    endfunction

endpackage

// File: rtl/cp0_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous level input.
module cp0_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages_r;

    // Shift the raw level through the flop chain; the last stage is the clean output.
    always_ff @(posedge clk) begin
        if (reset) begin
            stages_r <= '0;
        end else begin
            stages_r <= {stages_r[STAGES-2:0], d};
        end
    end

    assign q = stages_r[STAGES-1];

endmodule

// File: rtl/cp0_irq_timer.sv
// CP0 interrupt source: Count/Compare timer, ext IRQ synchronizers,
// software IP bits and the registered interrupt request.
module cp0_irq_timer
    import cp0_pkg::*;
#(
    parameter int NUM_EXT_IRQ = 5,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_DIV   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq,
    input  logic                   sw_ip_we,
    input  logic                   count_we,
    input  logic                   compare_we,
    input  logic [31:0]            cp0_wdata,
    input  logic [7:0]             status_im,
    input  logic                   status_ie,
    input  logic                   status_exl,
    output logic [31:0]            count,
    output logic [31:0]            compare,
    output logic [7:0]             interrupts,
    output logic                   irq_request
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0]          prescaler_r;
    logic                   tick_s;
    logic                   incremented_r;
    logic                   timer_pending_r;
    logic [1:0]             sw_ip_r;
    logic [NUM_EXT_IRQ-1:0] ext_sync_s;

    assign tick_s = (prescaler_r == PRESCALE_LAST);

    // Prescaler and Count; a Count write wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r   <= '0;
            count         <= 32'd0;
            incremented_r <= 1'b0;
        end else if (count_we) begin
            prescaler_r   <= '0;
            count         <= cp0_wdata;
            incremented_r <= 1'b0;
        end else if (tick_s) begin
            prescaler_r   <= '0;
            count         <= count + 32'd1;
            incremented_r <= 1'b1;
        end else begin
            prescaler_r   <= prescaler_r + PW'(1);
            count         <= count;
            incremented_r <= 1'b0;
        end
    end

    // Compare register.
    always_ff @(posedge clk) begin
        if (reset) begin
            compare <= 32'd0;
        end else if (compare_we) begin
            compare <= cp0_wdata;
        end else begin
            compare <= compare;
        end
    end

    // Sticky timer pending: set only when Count has just incremented onto
    // Compare (never by a load), cleared by a Compare write which also wins ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_pending_r <= 1'b0;
        end else if (compare_we) begin
            timer_pending_r <= 1'b0;
        end else if (incremented_r && (count == compare)) begin
            timer_pending_r <= 1'b1;
        end else begin
            timer_pending_r <= timer_pending_r;
        end
    end

    // Software-writable IP[1:0], taken from Cause bits 9:8.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_ip_r <= 2'b00;
        end else if (sw_ip_we) begin
            sw_ip_r <= cp0_wdata[9:8];
        end else begin
            sw_ip_r <= sw_ip_r;
        end
    end

    for (genvar i = 0; i < NUM_EXT_IRQ; i++) begin : g_ext_sync
        cp0_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .reset(reset),
            .d    (ext_irq[i]),
            .q    (ext_sync_s[i])
        );
    end

    assign interrupts = pack_interrupts(timer_pending_r, ext_sync_s, sw_ip_r);

    // Request is re-evaluated every cycle, so it drops as soon as EXL or the source does.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_request <= 1'b0;
        end else begin
            irq_request <= irq_wanted(status_ie, status_exl, interrupts, status_im);
        end
    end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Directed bench for cp0_irq_timer with a cycle-level behavioural model.
module tb_cp0_irq_timer;

    localparam int SYNC = 2;
    localparam int DIV  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ext_irq;
    logic        sw_ip_we, count_we, compare_we;
    logic [31:0] cp0_wdata;
    logic [7:0]  status_im;
    logic        status_ie, status_exl;
    logic [31:0] count, compare;
    logic [7:0]  interrupts;
    logic        irq_request;

    int tests = 0;
    int fails = 0;

    cp0_irq_timer #(.NUM_EXT_IRQ(5), .SYNC_STAGES(SYNC), .COUNT_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .ext_irq(ext_irq), .sw_ip_we(sw_ip_we),
        .count_we(count_we), .compare_we(compare_we), .cp0_wdata(cp0_wdata),
        .status_im(status_im), .status_ie(status_ie), .status_exl(status_exl),
        .count(count), .compare(compare), .interrupts(interrupts),
        .irq_request(irq_request)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_count, m_compare;
    int          m_phase;
    bit          m_just_inc, m_pend, m_irq, m_valid;
    logic [1:0]  m_sw;
    logic [4:0]  m_ext;
    logic [4:0]  hist[$];

    task automatic model_step();
        logic [7:0] old_ip;
        old_ip = {m_pend, m_ext, m_sw};
        if (reset) begin
            m_count = 32'd0; m_compare = 32'd0; m_phase = 0; m_just_inc = 1'b0;
            m_pend = 1'b0; m_irq = 1'b0; m_sw = 2'b00; m_ext = 5'd0;
            hist = {};
            for (int i = 0; i < SYNC; i++) hist.push_back(5'd0);
            m_valid = 1'b1;
        end else begin
            m_irq = status_ie && !status_exl && ((old_ip & status_im) != 8'h00);
            if (compare_we) m_pend = 1'b0;
            else if (m_just_inc && (m_count == m_compare)) m_pend = 1'b1;
            if (count_we) begin
                m_count = cp0_wdata; m_phase = 0; m_just_inc = 1'b0;
            end else if (m_phase == DIV - 1) begin
                m_count = m_count + 32'd1; m_phase = 0; m_just_inc = 1'b1;
            end else begin
                m_phase = m_phase + 1; m_just_inc = 1'b0;
            end
            if (compare_we) m_compare = cp0_wdata;
            if (sw_ip_we) m_sw = cp0_wdata[9:8];
            hist.push_front(ext_irq);
            void'(hist.pop_back());
            m_ext = hist[SYNC-1];
        end
    endtask

    // Every-cycle comparison against the model, sampled just after the edge.
    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (m_valid) begin
                check("model_count", count, m_count);
                check("model_compare", compare, m_compare);
                check("model_interrupts", {24'd0, interrupts}, {24'd0, m_pend, m_ext, m_sw});
                check("model_irq", {31'd0, irq_request}, {31'd0, m_irq});
            end
        end
    end

    task automatic wr_compare(input logic [31:0] v);
        compare_we = 1'b1; cp0_wdata = v;
        @(negedge clk);
        compare_we = 1'b0;
    endtask

    task automatic wr_count(input logic [31:0] v);
        count_we = 1'b1; cp0_wdata = v;
        @(negedge clk);
        count_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ext_irq = 5'd0; sw_ip_we = 1'b0; count_we = 1'b0;
        compare_we = 1'b0; cp0_wdata = 32'd0; status_im = 8'h00;
        status_ie = 1'b0; status_exl = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_count", count, 32'd0);
        check("reset_interrupts", {24'd0, interrupts}, 32'h00);
        check("reset_irq", {31'd0, irq_request}, 32'd0);
        reset = 1'b0;

        // 1: compare 10, count from 0 reaches 10 after 20 cycles, pending one later
        wr_compare(32'd10);
        wr_count(32'd0);
        repeat (20) @(negedge clk);
        check("t1_count10", count, 32'd10);
        check("t1_pend_not_yet", {31'd0, interrupts[7]}, 32'd0);
        @(negedge clk);
        check("t1_pend_set", {31'd0, interrupts[7]}, 32'd1);
        wr_compare(32'd50);
        check("t1_pend_cleared", {31'd0, interrupts[7]}, 32'd0);

        // 2: wrap FFFF_FFFF -> 0 matches compare 0
        wr_compare(32'd0);
        wr_count(32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        check("t2_count_max", count, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        check("t2_count_wrap", count, 32'd0);
        check("t2_pend_not_yet", {31'd0, interrupts[7]}, 32'd0);
        @(negedge clk);
        check("t2_pend_set", {31'd0, interrupts[7]}, 32'd1);

        // 3: compare write on the match cycle wins; loading count==compare never matches
        wr_compare(32'd20);
        wr_count(32'd18);
        repeat (4) @(negedge clk);
        check("t3_count_at_match", count, 32'd20);
        wr_compare(32'd77);
        check("t3_compare_loaded", compare, 32'd77);
        check("t3_no_pend", {31'd0, interrupts[7]}, 32'd0);
        @(negedge clk);
        check("t3_still_no_pend", {31'd0, interrupts[7]}, 32'd0);
        wr_compare(32'd10);
        wr_count(32'd10);
        repeat (3) @(negedge clk);
        check("t3_count_after_load", count, 32'd11);
        check("t3_load_no_pend", {31'd0, interrupts[7]}, 32'd0);

        // 4: ext_irq[2] 5-cycle pulse, seen on interrupts[4] after SYNC, request one later
        status_im = 8'h10; status_ie = 1'b1; status_exl = 1'b0;
        ext_irq = 5'b00100;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 5) ext_irq = 5'b00000;
            check($sformatf("t4_int4_c%0d", i), {31'd0, interrupts[4]},
                  {31'd0, (i >= 2 && i <= 6)});
            check($sformatf("t4_irq_c%0d", i), {31'd0, irq_request},
                  {31'd0, (i >= 3 && i <= 7)});
        end

        // 5: software bits and the IE/EXL gate
        status_im = 8'h03; status_ie = 1'b0; status_exl = 1'b0;
        sw_ip_we = 1'b1; cp0_wdata = 32'h0000_0300;
        @(negedge clk);
        sw_ip_we = 1'b0;
        check("t5_sw_bits", {30'd0, interrupts[1:0]}, 32'd3);
        @(negedge clk);
        check("t5_irq_ie0", {31'd0, irq_request}, 32'd0);
        status_ie = 1'b1; status_exl = 1'b1;
        @(negedge clk);
        check("t5_irq_exl1", {31'd0, irq_request}, 32'd0);
        status_exl = 1'b0;
        @(negedge clk);
        check("t5_irq_rise", {31'd0, irq_request}, 32'd1);
        status_exl = 1'b1;
        @(negedge clk);
        check("t5_irq_drop", {31'd0, irq_request}, 32'd0);
        status_exl = 1'b0;

        // 6: reset mid-count with pending and sw_ip=01 overrides a count write
        sw_ip_we = 1'b1; cp0_wdata = 32'h0000_0100;
        @(negedge clk);
        sw_ip_we = 1'b0;
        wr_compare(32'd101);
        wr_count(32'd100);
        repeat (3) @(negedge clk);
        check("t6_pre_reset_ip", {24'd0, interrupts}, 32'h81);
        reset = 1'b1; count_we = 1'b1; cp0_wdata = 32'd55;
        @(negedge clk);
        check("t6_count", count, 32'd0);
        check("t6_compare", compare, 32'd0);
        check("t6_interrupts", {24'd0, interrupts}, 32'h00);
        check("t6_irq", {31'd0, irq_request}, 32'd0);
        reset = 1'b0; count_we = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
